// File: rtl/pressure_classifier.sv
// Debounced, hysteretic pressure-level classifier feeding the compressor alternator.
// Define PRESS_WDOG_EN to build the stalled-sensor watchdog that drives Fault.
module pressure_classifier #(
    parameter int W       = 8,
    parameter int TH_A    = 200,
    parameter int TH_B    = 100,
    parameter int TH_MB   = 50,
    parameter int HYST    = 10,
    parameter int DEB     = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         SampleValid,
    input  logic [W-1:0] Sample,
    output logic         PA,
    output logic         PB,
    output logic         PMB,
    output logic         Changed,
    output logic         Fault
);

    localparam int CW  = $clog2(DEB + 1);
    localparam int CW1 = CW + 1;

    localparam logic [W-1:0] A_HI  = W'(TH_A);
    localparam logic [W-1:0] A_LO  = W'(TH_A - HYST);
    localparam logic [W-1:0] B_LO  = W'(TH_B);
    localparam logic [W-1:0] B_HI  = W'(TH_B + HYST);
    localparam logic [W-1:0] MB_LO = W'(TH_MB);
    localparam logic [W-1:0] MB_HI = W'(TH_MB + HYST);
    localparam logic [CW:0]  DEB_C = CW1'(DEB);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ALTA    = 2'd1,
        BAJA    = 2'd2,
        MUYBAJA = 2'd3
    } level_t;

    level_t        state_r;
    level_t        cand_r;
    level_t        target_s;
    logic [CW-1:0] cnt_r;
    logic [CW:0]   cnt_inc_s;
    logic [2:0]    flags_r;
    logic          changed_r;

    // One-hot {PA,PB,PMB} code for a level; only these four codes exist.
    function automatic logic [2:0] level_flags(input level_t lvl);
        logic [2:0] f;
        case (lvl)
            ALTA:    f = 3'b100;
            BAJA:    f = 3'b010;
            MUYBAJA: f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    // Target level: holding the current band first gives hysteresis.
    always_comb begin
        target_s = NORMAL;
        if (state_r == ALTA && Sample >= A_LO) begin
            target_s = ALTA;
        end else if (state_r == BAJA && Sample > MB_LO && Sample <= B_HI) begin
            target_s = BAJA;
        end else if (state_r == MUYBAJA && Sample <= MB_HI) begin
            target_s = MUYBAJA;
        end else if (Sample >= A_HI) begin
            target_s = ALTA;
        end else if (Sample <= MB_LO) begin
            target_s = MUYBAJA;
        end else if (Sample <= B_LO) begin
            target_s = BAJA;
        end else begin
            target_s = NORMAL;
        end
    end

    assign cnt_inc_s = {1'b0, cnt_r} + CW1'(1);

    // Debounce: a level commits only after DEB agreeing valid samples.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= NORMAL;
            cand_r    <= NORMAL;
            cnt_r     <= CW'(0);
            flags_r   <= 3'b000;
            changed_r <= 1'b0;
        end else begin
            changed_r <= 1'b0;
            if (SampleValid) begin
                if (target_s == state_r) begin
                    cnt_r <= CW'(0);
                end else if (target_s == cand_r) begin
                    if (cnt_inc_s == DEB_C) begin
                        state_r   <= target_s;
                        flags_r   <= level_flags(target_s);
                        cnt_r     <= CW'(0);
                        changed_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s[CW-1:0];
                    end
                end else begin
                    cand_r <= target_s;
                    if (DEB == 1) begin
                        state_r   <= target_s;
                        flags_r   <= level_flags(target_s);
                        cnt_r     <= CW'(0);
                        changed_r <= 1'b1;
                    end else begin
                        cnt_r <= CW'(1);
                    end
                end
            end
        end
    end

    assign PA      = flags_r[2];
    assign PB      = flags_r[1];
    assign PMB     = flags_r[0];
    assign Changed = changed_r;

`ifdef PRESS_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_r;
    logic          fault_r;

    // Idle-cycle counter; saturates at TIMEOUT and latches Fault until the next sample.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wdog_r  <= TW'(0);
            fault_r <= 1'b0;
        end else if (SampleValid) begin
            wdog_r  <= TW'(0);
            fault_r <= 1'b0;
        end else if (wdog_r != TW'(TIMEOUT)) begin
            wdog_r <= wdog_r + TW'(1);
            if (wdog_r == TW'(TIMEOUT - 1)) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign Fault = fault_r;
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_pressure_classifier.sv
// Directed self-checking bench for pressure_classifier with default parameters.
module tb_pressure_classifier;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       SampleValid;
    logic [7:0] Sample;
    logic       PA, PB, PMB, Changed, Fault;

    int n_checks   = 0;
    int n_fail     = 0;
    int chg_seen   = 0;
    bit multi_hot  = 1'b0;

    pressure_classifier dut (
        .Clk(Clk), .Reset(Reset), .SampleValid(SampleValid), .Sample(Sample),
        .PA(PA), .PB(PB), .PMB(PMB), .Changed(Changed), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    // Count Changed pulses and watch for any multi-hot level code.
    always @(negedge Clk) begin
        if (Changed) chg_seen++;
        if ($countones({PA, PB, PMB}) > 1) multi_hot = 1'b1;
    end

    task automatic step(input logic v, input logic [7:0] s);
        SampleValid = v;
        Sample      = s;
        @(negedge Clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] s, input int n);
        repeat (n) step(1'b1, s);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1'b0, 8'd0);
        Reset = 1'b0;
        step(1'b0, 8'd0);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(1'b0, 8'd0);
        n_checks++;
        if ({PA, PB, PMB, Changed, Fault} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_init: got %b want 00000", {PA, PB, PMB, Changed, Fault});
        end
        Reset = 1'b0;
        feed(8'd210, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL reset_pre_alta: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd20, 2);
        SampleValid = 1'b0;
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if ({PA, PB, PMB, Changed, Fault} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_async: got %b want 00000", {PA, PB, PMB, Changed, Fault});
        end
        #1 Reset = 1'b0;
        step(1'b0, 8'd0);
        feed(8'd20, 1);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL reset_discards_cnt: got %b want 000", {PA, PB, PMB});
        end
        feed(8'd20, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b001) begin
            n_fail++; $display("FAIL reset_recount: got %b want 001", {PA, PB, PMB});
        end
    endtask

    task automatic test_rise();
        int c0;
        do_reset();
        feed(8'd150, 1);
        feed(8'd210, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL rise_early: got %b want 000", {PA, PB, PMB});
        end
        c0 = chg_seen;
        feed(8'd210, 1);
        n_checks++;
        if ({PA, PB, PMB, Changed} !== 4'b1001) begin
            n_fail++; $display("FAIL rise_commit: got %b want 1001", {PA, PB, PMB, Changed});
        end
        step(1'b0, 8'd0);
        n_checks++;
        if (Changed !== 1'b0 || (chg_seen - c0) != 1) begin
            n_fail++; $display("FAIL rise_pulse: changed=%b pulses=%0d want 0 and 1", Changed, chg_seen - c0);
        end
        feed(8'd195, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL rise_hyst_hold: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd185, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL fall_early: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd185, 1);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL fall_normal: got %b want 000", {PA, PB, PMB});
        end
    endtask

    task automatic test_debounce_restart();
        feed(8'd90, 2);
        feed(8'd150, 1);
        feed(8'd90, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL deb_restart: got %b want 000", {PA, PB, PMB});
        end
        feed(8'd90, 1);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b010) begin
            n_fail++; $display("FAIL deb_baja: got %b want 010", {PA, PB, PMB});
        end
    endtask

    task automatic test_very_low();
        feed(8'd40, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b001) begin
            n_fail++; $display("FAIL vlow_enter: got %b want 001", {PA, PB, PMB});
        end
        feed(8'd55, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b001) begin
            n_fail++; $display("FAIL vlow_hyst: got %b want 001", {PA, PB, PMB});
        end
        feed(8'd61, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b001) begin
            n_fail++; $display("FAIL vlow_exit_early: got %b want 001", {PA, PB, PMB});
        end
        feed(8'd61, 1);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b010) begin
            n_fail++; $display("FAIL vlow_exit: got %b want 010", {PA, PB, PMB});
        end
    endtask

    task automatic test_thresholds();
        feed(8'd110, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b010) begin
            n_fail++; $display("FAIL thr_b_hold110: got %b want 010", {PA, PB, PMB});
        end
        feed(8'd111, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL thr_b_exit111: got %b want 000", {PA, PB, PMB});
        end
        feed(8'd199, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b000) begin
            n_fail++; $display("FAIL thr_a_199: got %b want 000", {PA, PB, PMB});
        end
        feed(8'd200, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL thr_a_200: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd190, 3);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL thr_a_hold190: got %b want 100", {PA, PB, PMB});
        end
    endtask

    task automatic test_direct_jump();
        feed(8'd20, 2);
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL jump_early: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd20, 1);
        n_checks++;
        if ({PA, PB, PMB, Changed} !== 4'b0011) begin
            n_fail++; $display("FAIL jump_vlow: got %b want 0011", {PA, PB, PMB, Changed});
        end
        n_checks++;
        if (multi_hot !== 1'b0) begin
            n_fail++; $display("FAIL one_hot: multi_hot seen=%b want 0", multi_hot);
        end
    endtask

    task automatic test_gaps();
        step(1'b1, 8'd200);
        repeat (4) step(1'b0, 8'd0);
        step(1'b1, 8'd200);
        step(1'b0, 8'd0);
        n_checks++;
        if ({PA, PB, PMB, Changed} !== 4'b0010) begin
            n_fail++; $display("FAIL gap_hold: got %b want 0010", {PA, PB, PMB, Changed});
        end
        step(1'b1, 8'd200);
        n_checks++;
        if ({PA, PB, PMB, Changed} !== 4'b1001) begin
            n_fail++; $display("FAIL gap_commit: got %b want 1001", {PA, PB, PMB, Changed});
        end
    endtask

    task automatic test_back_to_back();
        repeat (3) begin
            feed(8'd20, 1);
            feed(8'd210, 1);
        end
        n_checks++;
        if ({PA, PB, PMB} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_alternate: got %b want 100", {PA, PB, PMB});
        end
        feed(8'd90, 3);
        n_checks++;
        if ({PA, PB, PMB, Changed} !== 4'b0101) begin
            n_fail++; $display("FAIL b2b_baja: got %b want 0101", {PA, PB, PMB, Changed});
        end
    endtask

    task automatic test_watchdog();
`ifdef PRESS_WDOG_EN
        repeat (999) step(1'b0, 8'd0);
        n_checks++;
        if (Fault !== 1'b0) begin
            n_fail++; $display("FAIL wdog_early: got %b want 0", Fault);
        end
        step(1'b0, 8'd0);
        n_checks++;
        if ({PA, PB, PMB, Fault} !== 4'b0101) begin
            n_fail++; $display("FAIL wdog_fault: got %b want 0101", {PA, PB, PMB, Fault});
        end
        step(1'b1, 8'd90);
        n_checks++;
        if ({PA, PB, PMB, Fault} !== 4'b0100) begin
            n_fail++; $display("FAIL wdog_clear: got %b want 0100", {PA, PB, PMB, Fault});
        end
`else
        repeat (1100) step(1'b0, 8'd0);
        n_checks++;
        if ({PA, PB, PMB, Fault} !== 4'b0100) begin
            n_fail++; $display("FAIL wdog_absent: got %b want 0100", {PA, PB, PMB, Fault});
        end
`endif
    endtask

    initial begin
        Reset       = 1'b1;
        SampleValid = 1'b0;
        Sample      = 8'd0;
        @(negedge Clk);
        #1;
        test_reset();
        test_rise();
        test_debounce_restart();
        test_very_low();
        test_thresholds();
        test_direct_jump();
        test_gaps();
        test_back_to_back();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
